// File: rtl/pci_pkg.sv
// Shared definitions for the simplified PCI bus: command codes, idle byte
// enables, active-low signal levels and the initiator state encoding.
package pci_pkg;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;
  localparam logic [3:0] CBE_IDLE      = 4'hF;

  // Bus control lines are active-low.
  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WAIT = 3'd2,
    ST_DATA = 3'd3,
    ST_TURN = 3'd4
  } pci_state_e;

endpackage

// File: rtl/pci_ad_tristate.sv
// AD bus pad: registered output enable plus 32-bit driver and sampler.
// The enable is computed from the next state so it is already valid in the
// first cycle of an address or write data phase, and clears on reset
// without waiting for a clock edge.
module pci_ad_tristate (
  input  logic        clk,
  input  logic        rst,
  input  logic        oe_next,
  input  logic [31:0] dout,
  output logic [31:0] din,
  inout  wire  [31:0] AD
);

  logic oe_q;

  // Output-enable register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_q <= 1'b0;
    end else begin
      oe_q <= oe_next;
    end
  end

  assign AD  = oe_q ? dout : 32'hzzzz_zzzz;
  assign din = AD;

endmodule

// File: rtl/pci_initiator.sv
// PCI bus master: one host request becomes an address phase followed by a
// burst of 1..MAX_LEN data phases, with target wait states, DEVSEL timeout
// (master abort) and target disconnect handling.
//
// Handshake semantics: a data beat transfers at a rising edge exactly when
// the FSM is in DATA with IRDY, TRDY and DEVSEL all low. On the host side
// WD_ACK is high in the cycle whose closing edge carries the write beat;
// the host must hold WDATA/WBE until it sees WD_ACK at that edge. RD_VALID
// is a one-cycle pulse with RDATA, with no back-pressure.
module pci_initiator
  import pci_pkg::*;
#(
  parameter int MAX_LEN        = 8,
  parameter int DEVSEL_TIMEOUT = 5,
  localparam int LEN_W         = $clog2(MAX_LEN + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             FRAME,
  inout  wire  [31:0]      AD,
  output logic [3:0]       CBE,
  output logic             IRDY,
  input  logic             TRDY,
  input  logic             DEVSEL,
  input  logic             REQ,
  input  logic             WR,
  input  logic [31:0]      ADDR,
  input  logic [LEN_W-1:0] LEN,
  input  logic [31:0]      WDATA,
  input  logic [3:0]       WBE,
  output logic             WD_ACK,
  output logic [31:0]      RDATA,
  output logic             RD_VALID,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output pci_state_e       dbg_state
);

  localparam int TMO_W = (DEVSEL_TIMEOUT < 2) ? 1 : $clog2(DEVSEL_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DEVSEL_TIMEOUT - 1);

  pci_state_e       state, next_state;
  logic [31:0]      addr_q;
  logic             wr_q;
  logic             err_q;
  logic [LEN_W-1:0] beats_left;
  logic [LEN_W-1:0] len_clamped;
  logic [TMO_W-1:0] tmo_cnt;
  logic             xfer;
  logic             last_beat;
  logic             oe_next;
  logic [31:0]      ad_dout;
  logic [31:0]      ad_din;

  assign dbg_state = state;

  // A zero length still moves one word; anything past MAX_LEN is capped.
  always_comb begin
    len_clamped = LEN;
    if (LEN == '0) begin
      len_clamped = LEN_W'(1);
    end else if (LEN > LEN_W'(MAX_LEN)) begin
      len_clamped = LEN_W'(MAX_LEN);
    end
  end

  assign xfer      = (state == ST_DATA) && (TRDY == ASSERTED) && (DEVSEL == ASSERTED);
  assign last_beat = (beats_left == LEN_W'(1));

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a claim in the last WAIT cycle still wins over abort.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (REQ) next_state = ST_ADDR;
      ST_ADDR: next_state = ST_WAIT;
      ST_WAIT: begin
        if (DEVSEL == ASSERTED) begin
          next_state = ST_DATA;
        end else if (tmo_cnt == TMO_LAST) begin
          next_state = ST_TURN;
        end
      end
      ST_DATA: begin
        if (DEVSEL == DEASSERTED) begin
          next_state = ST_TURN;
        end else if (xfer && last_beat) begin
          next_state = ST_TURN;
        end
      end
      ST_TURN: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Output decode: bus controls, host strobes and the AD drive selection.
  always_comb begin
    FRAME   = DEASSERTED;
    IRDY    = DEASSERTED;
    CBE     = CBE_IDLE;
    WD_ACK  = 1'b0;
    BUSY    = (state != ST_IDLE);
    DONE    = 1'b0;
    ERR     = 1'b0;
    ad_dout = WDATA;
    case (state)
      ST_ADDR: begin
        FRAME   = ASSERTED;
        CBE     = wr_q ? CMD_MEM_WRITE : CMD_MEM_READ;
        ad_dout = addr_q;
      end
      ST_WAIT: begin
        FRAME = ASSERTED;
      end
      ST_DATA: begin
        FRAME  = last_beat ? DEASSERTED : ASSERTED;
        IRDY   = ASSERTED;
        CBE    = WBE;
        WD_ACK = xfer && wr_q;
      end
      ST_TURN: begin
        DONE = 1'b1;
        ERR  = err_q;
      end
      default: ;
    endcase
  end

  // AD is driven only for the address phase and write data phases.
  assign oe_next = (next_state == ST_ADDR) || ((next_state == ST_DATA) && wr_q);

  // Request latch, beat counter, DEVSEL timeout counter and error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q     <= '0;
      wr_q       <= 1'b0;
      beats_left <= '0;
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQ) begin
            addr_q     <= ADDR;
            wr_q       <= WR;
            beats_left <= len_clamped;
            err_q      <= 1'b0;
          end
        end
        ST_ADDR: tmo_cnt <= '0;
        ST_WAIT: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if ((DEVSEL == DEASSERTED) && (tmo_cnt == TMO_LAST)) begin
            err_q <= 1'b1;
          end
        end
        ST_DATA: begin
          if (DEVSEL == DEASSERTED) begin
            err_q <= 1'b1;
          end else if (xfer) begin
            beats_left <= beats_left - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Read capture: the word on AD at the transfer edge, flagged next cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RDATA    <= '0;
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= xfer && !wr_q;
      if (xfer && !wr_q) begin
        RDATA <= ad_din;
      end
    end
  end

  pci_ad_tristate u_ad (
    .clk     (CLK),
    .rst     (RST),
    .oe_next (oe_next),
    .dout    (ad_dout),
    .din     (ad_din),
    .AD      (AD)
  );

endmodule

// File: tb/tb_pci_initiator.sv
// Bench for pci_initiator: behavioural memory target on the AD bus, host
// driver tasks, read-data scoreboard and bus monitor.
module tb_pci_initiator;
  import pci_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int TMO     = 5;
  localparam int LW      = $clog2(MAX_LEN + 1);

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  wire  [31:0]   AD;
  logic          FRAME, IRDY, TRDY, DEVSEL, REQ, WR, WD_ACK, RD_VALID, BUSY, DONE, ERR;
  logic [3:0]    CBE, WBE;
  logic [31:0]   ADDR, WDATA, RDATA;
  logic [LW-1:0] LEN;
  pci_state_e    dbg_state;

  pci_initiator #(.MAX_LEN(MAX_LEN), .DEVSEL_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .FRAME(FRAME), .AD(AD), .CBE(CBE), .IRDY(IRDY),
    .TRDY(TRDY), .DEVSEL(DEVSEL), .REQ(REQ), .WR(WR), .ADDR(ADDR), .LEN(LEN),
    .WDATA(WDATA), .WBE(WBE), .WD_ACK(WD_ACK), .RDATA(RDATA), .RD_VALID(RD_VALID),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .dbg_state(dbg_state)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be_n);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (!be_n[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  function automatic int eff_len(input logic [LW-1:0] len);
    int l;
    l = int'(len);
    if (l == 0) return 1;
    if (l > MAX_LEN) return MAX_LEN;
    return l;
  endfunction

  // ---------------- target model ----------------
  logic [31:0] mem [16];
  logic        t_active, t_wr;
  logic [3:0]  t_idx;
  int          t_beat, stall_left;
  logic        devsel_en = 1'b1;
  int          stall_beat = -1;
  int          stall_cycles = 0;

  assign DEVSEL = !t_active;
  assign TRDY   = !(t_active && !((t_beat == stall_beat) && (stall_left != 0)));
  wire t_drive  = t_active && !t_wr && (IRDY == 1'b0);
  assign AD     = t_drive ? mem[t_idx] : 32'hzzzz_zzzz;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      t_active   <= 1'b0;
      t_wr       <= 1'b0;
      t_idx      <= '0;
      t_beat     <= 0;
      stall_left <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= pat(i);
    end else if (!t_active) begin
      if (devsel_en && FRAME == 1'b0 && IRDY == 1'b1) begin
        t_active   <= 1'b1;
        t_wr       <= (CBE == CMD_MEM_WRITE);
        t_idx      <= AD[5:2];
        t_beat     <= 0;
        stall_left <= stall_cycles;
      end
    end else begin
      if (IRDY == 1'b0 && TRDY == 1'b1 && stall_left > 0) stall_left <= stall_left - 1;
      if (IRDY == 1'b0 && TRDY == 1'b0) begin
        if (t_wr) mem[t_idx] <= merge(mem[t_idx], AD, CBE);
        t_idx  <= 4'(t_idx + 4'd1);
        t_beat <= t_beat + 1;
        if (FRAME == 1'b1) t_active <= 1'b0;
      end else if (FRAME == 1'b1 && IRDY == 1'b1) begin
        t_active <= 1'b0;
      end
    end
  end

  // ---------------- host write-data source ----------------
  logic [31:0] wdata_arr [16];
  logic [3:0]  wbe_arr [16];
  logic [3:0]  rd_wbe = 4'h0;
  logic        wr_mode = 1'b0;
  int          wr_idx = 0;
  always @(posedge CLK) begin
    if (REQ && !BUSY) wr_idx <= 0;
    else if (WD_ACK) wr_idx <= wr_idx + 1;
  end
  assign WDATA = wdata_arr[wr_idx % 16];
  assign WBE   = wr_mode ? wbe_arr[wr_idx % 16] : rd_wbe;

  // ---------------- monitor ----------------
  logic [31:0] got_q[$];
  int   cyc = 0, xfer_cnt = 0, ack_cnt = 0, done_cnt = 0, err_cnt = 0, frame_hi_xfer = 0;
  int   addr_cyc = 0, done_cyc = 0, wait_cyc = 0, stable_errs = 0, contention_errs = 0;
  logic last_xfer_frame = 1'b0, prev_frame = 1'b1, snap_valid = 1'b0;
  logic [37:0] snap = '0;

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (IRDY == 1'b0 && TRDY == 1'b0 && DEVSEL == 1'b0) begin
      xfer_cnt = xfer_cnt + 1;
      last_xfer_frame = FRAME;
      if (FRAME) frame_hi_xfer = frame_hi_xfer + 1;
    end
    if (WD_ACK) ack_cnt = ack_cnt + 1;
    if (RD_VALID) got_q.push_back(RDATA);
    if (FRAME == 1'b0 && prev_frame == 1'b1) addr_cyc = cyc;
    if (DONE) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      if (ERR) err_cnt = err_cnt + 1;
    end
    if (IRDY == 1'b0 && TRDY == 1'b1) begin
      wait_cyc = wait_cyc + 1;
      if (snap_valid && snap != {FRAME, CBE, AD, WD_ACK}) stable_errs = stable_errs + 1;
      snap = {FRAME, CBE, AD, WD_ACK};
      snap_valid = 1'b1;
    end else begin
      snap_valid = 1'b0;
    end
    if (t_drive && AD != mem[t_idx]) contention_errs = contention_errs + 1;
    prev_frame = FRAME;
  end

  // ---------------- scoreboard / checking ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_mem [16];
  int checks = 0, errors = 0, rd_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drain_reads(input string tag);
    check({tag, "_rd_count"}, 32'(got_q.size() - rd_seen), 32'(exp_q.size()));
    while (exp_q.size() > 0 && rd_seen < got_q.size()) begin
      check(tag, got_q[rd_seen], exp_q.pop_front());
      rd_seen++;
    end
    exp_q.delete();
    rd_seen = got_q.size();
  endtask

  task automatic check_mem(input string tag, input int first, input int n);
    for (int i = first; i < first + n; i++) check(tag, mem[i % 16], exp_mem[i % 16]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    RST = 1'b1;
    for (int i = 0; i < 16; i++) exp_mem[i] = pat(i);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic start_cmd(input logic wr, input logic [31:0] addr, input logic [LW-1:0] len);
    @(negedge CLK);
    wr_mode = wr;
    WR = wr; ADDR = addr; LEN = len; REQ = 1'b1;
    @(negedge CLK);
    REQ = 1'b0;
  endtask

  task automatic issue_write(input logic [31:0] addr, input logic [LW-1:0] len);
    int idx;
    idx = int'(addr[5:2]);
    for (int i = 0; i < eff_len(len); i++)
      exp_mem[(idx + i) % 16] = merge(exp_mem[(idx + i) % 16], wdata_arr[i], wbe_arr[i]);
    start_cmd(1'b1, addr, len);
  endtask

  task automatic issue_read(input logic [31:0] addr, input logic [LW-1:0] len);
    int idx;
    idx = int'(addr[5:2]);
    for (int i = 0; i < eff_len(len); i++) exp_q.push_back(exp_mem[(idx + i) % 16]);
    start_cmd(1'b0, addr, len);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!DONE && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_done_seen"}, 32'(DONE), 32'd1);
    @(negedge CLK);
    @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  int x0, a0, d0, e0, f0, w0;

  initial begin
    REQ = 1'b0; WR = 1'b0; ADDR = '0; LEN = '0;
    for (int i = 0; i < 16; i++) begin wdata_arr[i] = '0; wbe_arr[i] = 4'h0; end
    #1;
    check("rst_frame", 32'(FRAME), 32'd1);
    check("rst_irdy", 32'(IRDY), 32'd1);
    check("rst_cbe", 32'(CBE), 32'hF);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_rdv", 32'(RD_VALID), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_wdack", 32'(WD_ACK), 32'd0);
    apply_reset();

    // Three-beat write with byte enables F/9/1, zero wait states.
    wdata_arr[0] = 32'hF0F0F0F0; wbe_arr[0] = 4'hF;
    wdata_arr[1] = 32'hFFFFFFFF; wbe_arr[1] = 4'h9;
    wdata_arr[2] = 32'hF0F0F0F0; wbe_arr[2] = 4'h1;
    x0 = xfer_cnt; a0 = ack_cnt; d0 = done_cnt; f0 = frame_hi_xfer;
    issue_write(32'h0, LW'(3));
    wait_done("wr3");
    check("wr3_acks", 32'(ack_cnt - a0), 32'd3);
    check("wr3_xfers", 32'(xfer_cnt - x0), 32'd3);
    check("wr3_dones", 32'(done_cnt - d0), 32'd1);
    check("wr3_frame_hi_beats", 32'(frame_hi_xfer - f0), 32'd1);
    check("wr3_frame_last", 32'(last_xfer_frame), 32'd1);
    check("wr3_mem1_const", mem[1], 32'hA5FFFF01);
    check_mem("wr3_mem", 0, 3);

    // Four-beat read of the written words.
    x0 = xfer_cnt;
    issue_read(32'h0, LW'(4));
    wait_done("rd4");
    check("rd4_xfers", 32'(xfer_cnt - x0), 32'd4);
    drain_reads("rd4");
    check("rd4_contention", 32'(contention_errs), 32'd0);

    // Two-beat write with three target wait states on beat 1.
    wdata_arr[0] = $urandom; wbe_arr[0] = 4'h0;
    wdata_arr[1] = $urandom; wbe_arr[1] = 4'hC;
    stall_beat = 0; stall_cycles = 3;
    a0 = ack_cnt; d0 = done_cnt; w0 = wait_cyc;
    issue_write(32'h10, LW'(2));
    wait_done("wrst");
    stall_beat = -1; stall_cycles = 0;
    check("wrst_acks", 32'(ack_cnt - a0), 32'd2);
    check("wrst_dones", 32'(done_cnt - d0), 32'd1);
    check("wrst_waits", 32'(wait_cyc - w0), 32'd3);
    check("wrst_stable", 32'(stable_errs), 32'd0);
    check_mem("wrst_mem", 4, 2);

    // No target: master abort after the DEVSEL timeout.
    devsel_en = 1'b0;
    a0 = ack_cnt; e0 = err_cnt; d0 = done_cnt;
    start_cmd(1'b1, 32'h40, LW'(2));
    wait_done("abort");
    devsel_en = 1'b1;
    check("abort_latency", 32'(done_cyc - addr_cyc), 32'(TMO + 1));
    check("abort_err", 32'(err_cnt - e0), 32'd1);
    check("abort_dones", 32'(done_cnt - d0), 32'd1);
    check("abort_acks", 32'(ack_cnt - a0), 32'd0);
    check("abort_frame", 32'(FRAME), 32'd1);
    check("abort_irdy", 32'(IRDY), 32'd1);
    check("abort_busy", 32'(BUSY), 32'd0);

    // LEN=0 read acts as one beat; a REQ pulse while busy is ignored.
    x0 = xfer_cnt; d0 = done_cnt; e0 = err_cnt;
    issue_read(32'h8, LW'(0));
    @(negedge CLK); REQ = 1'b1;
    @(negedge CLK); REQ = 1'b0;
    wait_done("len0");
    repeat (6) @(negedge CLK);
    check("len0_xfers", 32'(xfer_cnt - x0), 32'd1);
    check("len0_dones", 32'(done_cnt - d0), 32'd1);
    check("len0_noerr", 32'(err_cnt - e0), 32'd0);
    check("len0_busy_after", 32'(BUSY), 32'd0);
    drain_reads("len0");

    // Over-long write is clamped to MAX_LEN, then read back.
    for (int i = 0; i < 16; i++) begin wdata_arr[i] = $urandom; wbe_arr[i] = 4'h0; end
    x0 = xfer_cnt; a0 = ack_cnt;
    issue_write(32'h20, LW'(MAX_LEN + 3));
    wait_done("wrmax");
    check("wrmax_acks", 32'(ack_cnt - a0), 32'(MAX_LEN));
    check("wrmax_xfers", 32'(xfer_cnt - x0), 32'(MAX_LEN));
    check_mem("wrmax_mem", 8, MAX_LEN);
    issue_read(32'h20, LW'(MAX_LEN));
    wait_done("rdmax");
    drain_reads("rdmax");

    // Reset during beat 2 of a four-beat read.
    start_cmd(1'b0, 32'h0, LW'(4));
    begin
      int n;
      n = 0;
      while (!(IRDY == 1'b0 && TRDY == 1'b0) && n < 50) begin
        @(negedge CLK);
        n++;
      end
      check("mrst_beat1_seen", 32'(n < 50), 32'd1);
    end
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("mrst_frame", 32'(FRAME), 32'd1);
    check("mrst_irdy", 32'(IRDY), 32'd1);
    check("mrst_busy", 32'(BUSY), 32'd0);
    check("mrst_cbe", 32'(CBE), 32'hF);
    apply_reset();
    exp_q.delete();
    rd_seen = got_q.size();

    // Traffic after reset runs normally.
    wdata_arr[0] = $urandom; wbe_arr[0] = 4'h0;
    a0 = ack_cnt; d0 = done_cnt;
    issue_write(32'h4, LW'(1));
    wait_done("post");
    check("post_acks", 32'(ack_cnt - a0), 32'd1);
    check("post_dones", 32'(done_cnt - d0), 32'd1);
    issue_read(32'h0, LW'(2));
    wait_done("postrd");
    drain_reads("postrd");
    check("final_contention", 32'(contention_errs), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
